// File: rtl/song_sequencer_ctrl.sv
// Beat-timed game controller: steps the song ROM address, judges debounced
// button patterns inside a per-beat hit window and keeps score, combo and misses.
module song_sequencer_ctrl #(
    parameter int TICKS_PER_BEAT = 8,
    parameter int HIT_WINDOW     = 4,
    parameter int SONG_LEN       = 128,
    parameter int SCORE_MAX      = 999
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic [4:0] btn_db,
    input  logic [4:0] song_note,
    output logic [6:0] songDataPos,
    output logic [1:0] countdown,
    output logic       playing,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [9:0] score,
    output logic [3:0] combo,
    output logic [6:0] misses,
    output logic       game_over
);

    localparam int TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BEAT - 1);
    localparam logic [TW-1:0] WIN_FIRST = TW'(2);
    localparam logic [TW-1:0] WIN_LAST  = TW'(HIT_WINDOW + 1);
    localparam logic [6:0]    POS_LAST  = 7'(SONG_LEN - 1);
    localparam logic [9:0]    SCORE_CAP = 10'(SCORE_MAX);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_PLAY      = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_tick,      w_tick_nxt;
    logic [1:0]      r_beat,      w_beat_nxt;
    logic [1:0]      r_countdown, w_countdown_nxt;
    logic [4:0]      r_note,      w_note_nxt;
    logic            r_attempted, w_attempted_nxt;
    logic [6:0]      r_pos,       w_pos_nxt;
    logic            r_playing,   w_playing_nxt;
    logic            r_game_over, w_game_over_nxt;
    logic            r_hit,       w_hit_nxt;
    logic            r_miss,      w_miss_nxt;
    logic [9:0]      r_score,     w_score_nxt;
    logic [3:0]      r_combo,     w_combo_nxt;
    logic [6:0]      r_misses,    w_misses_nxt;

    logic w_tick_wrap;
    logic w_in_window;
    logic w_attempt;
    logic w_late_miss;
    logic w_judge_hit;
    logic w_judge_miss;

    function automatic logic [9:0] f_score_add(input logic [9:0] cur, input logic bonus);
        logic [10:0] sum;
        sum = {1'b0, cur} + (bonus ? 11'd2 : 11'd1);
        if (sum > {1'b0, SCORE_CAP}) begin
            f_score_add = SCORE_CAP;
        end else begin
            f_score_add = sum[9:0];
        end
    endfunction

    function automatic logic [3:0] f_combo_inc(input logic [3:0] cur);
        f_combo_inc = (cur == 4'd15) ? cur : cur + 4'd1;
    endfunction

    function automatic logic [6:0] f_misses_inc(input logic [6:0] cur);
        f_misses_inc = (cur == 7'd127) ? cur : cur + 7'd1;
    endfunction

    assign w_tick_wrap  = (r_tick == TICK_LAST);
    assign w_in_window  = (r_tick >= WIN_FIRST) && (r_tick <= WIN_LAST);
    // Only the first nonzero press inside the window of a non-rest beat is judged.
    assign w_attempt    = (r_state == S_PLAY) && w_in_window && !r_attempted &&
                          (btn_db != 5'd0) && (r_note != 5'd0);
    assign w_late_miss  = (r_state == S_PLAY) && w_tick_wrap && !r_attempted &&
                          !w_attempt && (r_note != 5'd0);
    assign w_judge_hit  = w_attempt && (btn_db == r_note);
    assign w_judge_miss = (w_attempt && (btn_db != r_note)) || w_late_miss;

    // Next-state selection for the game FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_COUNTDOWN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_COUNTDOWN: begin
                if (w_tick_wrap && (r_beat == 2'd3)) begin
                    w_state_nxt = S_PLAY;
                end else begin
                    w_state_nxt = S_COUNTDOWN;
                end
            end
            S_PLAY: begin
                if (w_tick_wrap && (r_pos == POS_LAST)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_COUNTDOWN;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next values for the counters, judge and score datapath.
    always_comb begin
        w_tick_nxt      = r_tick;
        w_beat_nxt      = r_beat;
        w_countdown_nxt = r_countdown;
        w_note_nxt      = r_note;
        w_attempted_nxt = r_attempted;
        w_pos_nxt       = r_pos;
        w_score_nxt     = r_score;
        w_combo_nxt     = r_combo;
        w_misses_nxt    = r_misses;
        w_hit_nxt       = 1'b0;
        w_miss_nxt      = 1'b0;
        w_playing_nxt   = (w_state_nxt == S_PLAY);
        w_game_over_nxt = (w_state_nxt == S_DONE);
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_tick_nxt      = '0;
                    w_beat_nxt      = 2'd0;
                    w_countdown_nxt = 2'd3;
                    w_note_nxt      = 5'd0;
                    w_attempted_nxt = 1'b0;
                    w_pos_nxt       = 7'd0;
                    w_score_nxt     = 10'd0;
                    w_combo_nxt     = 4'd0;
                    w_misses_nxt    = 7'd0;
                end else begin
                    w_tick_nxt      = r_tick;
                end
            end
            S_COUNTDOWN: begin
                if (w_tick_wrap) begin
                    w_tick_nxt      = '0;
                    w_beat_nxt      = r_beat + 2'd1;
                    w_countdown_nxt = (r_beat == 2'd3) ? 2'd0 : r_countdown - 2'd1;
                end else begin
                    w_tick_nxt      = r_tick + TICK_ONE;
                end
            end
            S_PLAY: begin
                if (w_tick_wrap) begin
                    w_tick_nxt      = '0;
                    w_attempted_nxt = 1'b0;
                    w_pos_nxt       = (r_pos == POS_LAST) ? r_pos : r_pos + 7'd1;
                end else begin
                    w_tick_nxt      = r_tick + TICK_ONE;
                    w_attempted_nxt = r_attempted | w_attempt;
                end
                // ROM data for the new address is valid one cycle after the wrap.
                if (r_tick == TICK_ONE) begin
                    w_note_nxt = song_note;
                end else begin
                    w_note_nxt = r_note;
                end
                if (w_judge_hit) begin
                    w_hit_nxt    = 1'b1;
                    w_score_nxt  = f_score_add(r_score, r_combo >= 4'd4);
                    w_combo_nxt  = f_combo_inc(r_combo);
                end else if (w_judge_miss) begin
                    w_miss_nxt   = 1'b1;
                    w_combo_nxt  = 4'd0;
                    w_misses_nxt = f_misses_inc(r_misses);
                end else begin
                    w_score_nxt  = r_score;
                end
            end
            default: begin
                w_tick_nxt = r_tick;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_tick      <= '0;
            r_beat      <= 2'd0;
            r_countdown <= 2'd0;
            r_note      <= 5'd0;
            r_attempted <= 1'b0;
            r_pos       <= 7'd0;
            r_playing   <= 1'b0;
            r_game_over <= 1'b0;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
            r_score     <= 10'd0;
            r_combo     <= 4'd0;
            r_misses    <= 7'd0;
        end else begin
            r_tick      <= w_tick_nxt;
            r_beat      <= w_beat_nxt;
            r_countdown <= w_countdown_nxt;
            r_note      <= w_note_nxt;
            r_attempted <= w_attempted_nxt;
            r_pos       <= w_pos_nxt;
            r_playing   <= w_playing_nxt;
            r_game_over <= w_game_over_nxt;
            r_hit       <= w_hit_nxt;
            r_miss      <= w_miss_nxt;
            r_score     <= w_score_nxt;
            r_combo     <= w_combo_nxt;
            r_misses    <= w_misses_nxt;
        end
    end

    assign songDataPos = r_pos;
    assign countdown   = r_countdown;
    assign playing     = r_playing;
    assign hit_pulse   = r_hit;
    assign miss_pulse  = r_miss;
    assign score       = r_score;
    assign combo       = r_combo;
    assign misses      = r_misses;
    assign game_over   = r_game_over;

endmodule

// File: doc/song_sequencer_ctrl.md
Name:
song_sequencer_ctrl

Overview:
- Game controller that sequences the Guitar Hero datapath.
- Steps the song-data address (songDataPos) at a fixed beat rate.
- Opens a hit window per note, judges debounced button patterns against the fetched note, and keeps score, combo and misses.
- Sits between the button debouncers and song ROM on one side and the score display controller on the other; replaces the free-running equality/point path with a timed judge.

Parameters:
- TICKS_PER_BEAT, 8, clk cycles per beat (≥ HIT_WINDOW+2).
- HIT_WINDOW, 4, ticks per beat in which a press is judged.
- SONG_LEN, 128, number of note slots (1..128).
- SCORE_MAX, 999, score saturation value.

Ports:
- clk  in  1  system clock.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  level; begins a game from IDLE or DONE.
- btn_db  in  5  debounced buttons.
- song_note  in  5  song ROM data, valid 1 cycle after songDataPos changes.
- songDataPos  out  7  song ROM address.
- countdown  out  2  beats remaining in countdown, 3..0.
- playing  out  1  high in PLAY.
- hit_pulse  out  1  one-cycle strobe on a judged hit.
- miss_pulse  out  1  one-cycle strobe on a judged miss.
- score  out  10  binary score, 0..SCORE_MAX.
- combo  out  4  consecutive hits, saturates at 15.
- misses  out  7  miss count, saturates at 127.
- game_over  out  1  high in DONE.

Behaviour:
- Reset (clear=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including tick and beat counters.
- States:
  - IDLE: waits for start=1, then enters COUNTDOWN. Score, combo and misses are cleared on this transition.
  - COUNTDOWN: 4 beats of TICKS_PER_BEAT cycles each. countdown=3,2,1,0, one value per beat. After the last tick, enter PLAY with songDataPos=0 and tick=0.
  - PLAY: tick counts 0..TICKS_PER_BEAT-1. At tick wrap, songDataPos increments. After wrap at songDataPos=SONG_LEN-1, enter DONE; songDataPos holds at its last value.
  - DONE: game_over=1; scores hold. start=1 enters COUNTDOWN, clearing score, combo, misses and songDataPos.
- Per-beat judging (PLAY only):
  - Note sampling: song_note is sampled into note_reg at tick=1.
  - Window: ticks 2..HIT_WINDOW+1.
  - Attempt: the first window cycle with btn_db≠0. Only one attempt per beat; later presses in the beat are ignored.
  - Attempt with btn_db==note_reg (exact 5-bit match) is a hit.
  - Attempt with any other nonzero pattern is a miss.
  - No attempt by the end of tick TICKS_PER_BEAT-1 with note_reg≠0 is a miss, strobed at tick TICKS_PER_BEAT-1.
  - note_reg==0 (rest): no judging, no strobes, any press ignored.
- Strobe and counter timing:
  - hit_pulse/miss_pulse are asserted the cycle after the judging event.
  - score, combo and misses update on the same edge as the strobe.
- Arithmetic:
  - Hit: score += 1, plus 1 extra if combo ≥ 4 before the increment. Score saturates at SCORE_MAX; combo += 1, saturating at 15.
  - Miss: combo=0; misses += 1, saturating at 127.
- Boundaries:
  - A press held across a beat boundary counts as an attempt again in the next window, because the level is sampled.
  - start is ignored in COUNTDOWN and PLAY.
  - clear mid-game aborts immediately to IDLE with all outputs 0.
  - A final-beat judgement strobe may coincide with entry to DONE; the counters still update.

Test Plan (TICKS_PER_BEAT=8, HIT_WINDOW=4, SONG_LEN=4):
- Reset then start pulse:
  - countdown steps 3,2,1,0 at 8-cycle intervals.
  - playing rises 32 cycles after start is registered, with songDataPos=0.
- Notes 5'b00001 ×4, each matched at tick 3:
  - 4 hit_pulse strobes.
  - score=4, combo=4, misses=0.
  - game_over=1 after songDataPos reaches 3 and wraps; songDataPos=3.
- Notes 5'b00010 ×2 with no presses:
  - miss_pulse at tick 7 of each beat; misses=2, combo=0.
- Note 5'b00100 with btn_db=5'b00110 at tick 2, then 5'b00100 at tick 4:
  - Single miss_pulse; the second press is ignored; score is unchanged.
- Preload score=998, combo=5, then a hit:
  - score=999 (saturated), combo=6.
  - A further hit keeps score=999.
- clear asserted during PLAY at tick 5:
  - Immediately all outputs are 0 and state is IDLE.
  - After release, start runs a fresh countdown with score=0.
